// File: rtl/pipe_mips32_fwd.sv
// pipe_mips32_fwd: 5-stage MIPS32-subset core (IF/ID/EX/MEM/WB) with optional
// EX/MEM + MEM/WB forwarding, load-use interlock, branch flush in EX and sticky halt.
module pipe_mips32_fwd #(
   parameter int DW         = 32,
   parameter int AW         = 10,
   parameter int FORWARD_EN = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_rdata,
   output logic [AW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   output logic          dmem_we,
   input  logic [DW-1:0] dmem_rdata,
   output logic          halted,
   output logic          retire_valid,
   input  logic [4:0]    dbg_reg_addr,
   output logic [DW-1:0] dbg_reg_data
);
   localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3;
   localparam logic [5:0] OP_SLT = 6'd4, OP_MUL = 6'd5, OP_LW = 6'd8, OP_SW = 6'd9;
   localparam logic [5:0] OP_ADDI = 6'd10, OP_SUBI = 6'd11, OP_SLTI = 6'd12;
   localparam logic [5:0] OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14;
   localparam bit FWD = (FORWARD_EN != 0);

   logic [DW-1:0] rf [32];
   logic [AW-1:0] pc;
   logic          fetch_stop;

   logic          ifid_valid;
   logic [31:0]   ifid_ir;
   logic [AW-1:0] ifid_npc;

   logic          idex_valid, idex_wr, idex_hlt;
   logic [5:0]    idex_op;
   logic [4:0]    idex_rs, idex_rt, idex_dest;
   logic [DW-1:0] idex_a, idex_b, idex_imm;
   logic [AW-1:0] idex_npc;

   logic          exmem_valid, exmem_wr, exmem_lw, exmem_sw, exmem_hlt;
   logic [4:0]    exmem_dest;
   logic [DW-1:0] exmem_alu, exmem_sd;

   logic          memwb_valid, memwb_wr, memwb_hlt;
   logic [4:0]    memwb_dest;
   logic [DW-1:0] memwb_res;

   // ID decode
   logic [5:0]    id_op;
   logic [4:0]    id_rs, id_rt, id_rd, id_dest;
   logic          id_rr, id_rm, id_lw, id_sw, id_br, id_hlt, id_wr, id_use_rs, id_use_rt;
   logic [DW-1:0] id_imm, id_a, id_b;

   assign id_op     = ifid_ir[31:26];
   assign id_rs     = ifid_ir[25:21];
   assign id_rt     = ifid_ir[20:16];
   assign id_rd     = ifid_ir[15:11];
   assign id_rr     = (id_op <= OP_MUL);
   assign id_rm     = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
   assign id_lw     = (id_op == OP_LW);
   assign id_sw     = (id_op == OP_SW);
   assign id_br     = (id_op == OP_BEQZ) || (id_op == OP_BNEQZ);
   assign id_hlt    = !(id_rr || id_rm || id_lw || id_sw || id_br);
   assign id_wr     = id_rr || id_rm || id_lw;
   assign id_dest   = id_rr ? id_rd : id_rt;
   assign id_use_rs = !id_hlt;
   assign id_use_rt = id_rr || id_sw;
   assign id_imm    = DW'(signed'(ifid_ir[15:0]));

   logic em_fwd, wb_we;
   assign em_fwd = exmem_valid && exmem_wr && (exmem_dest != 5'd0);
   assign wb_we  = memwb_valid && memwb_wr && (memwb_dest != 5'd0);

   // Register read with write-through from the WB write of the same cycle
   assign id_a = (id_rs == 5'd0) ? '0 : (wb_we && memwb_dest == id_rs) ? memwb_res : rf[id_rs];
   assign id_b = (id_rt == 5'd0) ? '0 : (wb_we && memwb_dest == id_rt) ? memwb_res : rf[id_rt];

   logic hz_ex, hz_mem, stall, id_hlt_v;
   assign hz_ex  = idex_valid && idex_wr && (idex_dest != 5'd0) &&
                   ((id_use_rs && idex_dest == id_rs) || (id_use_rt && idex_dest == id_rt));
   assign hz_mem = em_fwd &&
                   ((id_use_rs && exmem_dest == id_rs) || (id_use_rt && exmem_dest == id_rt));
   assign stall    = ifid_valid && (FWD ? (hz_ex && idex_op == OP_LW) : (hz_ex || hz_mem));
   assign id_hlt_v = ifid_valid && id_hlt;

   // EX operands: EX/MEM result wins over MEM/WB, which wins over the ID/EX copy
   logic [DW-1:0] ex_a, ex_b, ex_alu;
   always_comb begin
      ex_a = idex_a;
      ex_b = idex_b;
      if (FWD) begin
         if (em_fwd && exmem_dest == idex_rs)     ex_a = exmem_alu;
         else if (wb_we && memwb_dest == idex_rs) ex_a = memwb_res;
         if (em_fwd && exmem_dest == idex_rt)     ex_b = exmem_alu;
         else if (wb_we && memwb_dest == idex_rt) ex_b = memwb_res;
      end
   end

   always_comb begin
      ex_alu = '0;
      case (idex_op)
         OP_ADD:               ex_alu = ex_a + ex_b;
         OP_SUB:               ex_alu = ex_a - ex_b;
         OP_AND:               ex_alu = ex_a & ex_b;
         OP_OR:                ex_alu = ex_a | ex_b;
         OP_SLT:               ex_alu = DW'(ex_a < ex_b);
         OP_MUL:               ex_alu = ex_a * ex_b;
         OP_LW, OP_SW, OP_ADDI: ex_alu = ex_a + idex_imm;
         OP_SUBI:              ex_alu = ex_a - idex_imm;
         OP_SLTI:              ex_alu = DW'(ex_a < idex_imm);
         default:              ex_alu = '0;
      endcase
   end

   logic          ex_taken;
   logic [AW-1:0] ex_target;
   assign ex_taken  = idex_valid && (((idex_op == OP_BEQZ) && (ex_a == '0)) ||
                                     ((idex_op == OP_BNEQZ) && (ex_a != '0)));
   assign ex_target = idex_npc + idex_imm[AW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0; fetch_stop <= 1'b0; halted <= 1'b0;
         ifid_valid <= 1'b0; ifid_ir <= '0; ifid_npc <= '0;
         idex_valid <= 1'b0; idex_wr <= 1'b0; idex_hlt <= 1'b0; idex_op <= '0;
         idex_rs <= '0; idex_rt <= '0; idex_dest <= '0;
         idex_a <= '0; idex_b <= '0; idex_imm <= '0; idex_npc <= '0;
         exmem_valid <= 1'b0; exmem_wr <= 1'b0; exmem_lw <= 1'b0; exmem_sw <= 1'b0;
         exmem_hlt <= 1'b0; exmem_dest <= '0; exmem_alu <= '0; exmem_sd <= '0;
         memwb_valid <= 1'b0; memwb_wr <= 1'b0; memwb_hlt <= 1'b0;
         memwb_dest <= '0; memwb_res <= '0;
      end else if (!halted) begin
         // A taken branch beats both a stall and an HLT waiting in ID
         if (ex_taken)                                 pc <= ex_target;
         else if (!(stall || fetch_stop || id_hlt_v)) pc <= pc + AW'(1);

         if (ex_taken) ifid_valid <= 1'b0;
         else if (!stall) begin
            if (fetch_stop || id_hlt_v) ifid_valid <= 1'b0;
            else begin
               ifid_valid <= 1'b1;
               ifid_ir    <= imem_rdata;
               ifid_npc   <= pc + AW'(1);
            end
         end
         if (id_hlt_v && !stall && !ex_taken) fetch_stop <= 1'b1;

         idex_valid <= ifid_valid && !stall && !ex_taken;
         idex_wr    <= id_wr;     idex_hlt  <= id_hlt;  idex_op  <= id_op;
         idex_rs    <= id_rs;     idex_rt   <= id_rt;   idex_dest <= id_dest;
         idex_a     <= id_a;      idex_b    <= id_b;    idex_imm <= id_imm;
         idex_npc   <= ifid_npc;

         exmem_valid <= idex_valid;
         exmem_wr    <= idex_wr;   exmem_hlt <= idex_hlt; exmem_dest <= idex_dest;
         exmem_lw    <= (idex_op == OP_LW);
         exmem_sw    <= (idex_op == OP_SW);
         exmem_alu   <= ex_alu;    exmem_sd  <= ex_b;

         memwb_valid <= exmem_valid;
         memwb_wr    <= exmem_wr;  memwb_hlt <= exmem_hlt; memwb_dest <= exmem_dest;
         memwb_res   <= exmem_lw ? dmem_rdata : exmem_alu;

         if (memwb_valid && memwb_hlt) halted <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (!halted && wb_we) begin
         rf[memwb_dest] <= memwb_res;
      end
   end

   assign imem_addr    = pc;
   assign dmem_addr    = exmem_alu[AW-1:0];
   assign dmem_wdata   = exmem_sd;
   assign dmem_we      = exmem_valid && exmem_sw && !halted;
   assign retire_valid = memwb_valid && !halted;
   assign dbg_reg_data = rf[dbg_reg_addr];
endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed-program bench: runs each program on a forwarding core and an interlock-only
// core side by side, with behavioural instruction/data memories.
module tb_pipe_mips32_fwd;
   localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4;
   localparam logic [5:0] MUL = 6'd5, LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11;
   localparam logic [5:0] SLTI = 6'd12, BNEQZ = 6'd13, BEQZ = 6'd14;
   localparam logic [31:0] HLT_W = 32'hFC00_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] imem   [0:1023];
   logic [31:0] dmem_f [0:1023];
   logic [31:0] dmem_n [0:1023];

   logic [9:0]  imem_addr_f, imem_addr_n, dmem_addr_f, dmem_addr_n;
   logic [31:0] imem_rdata_f, imem_rdata_n, dmem_rdata_f, dmem_rdata_n;
   logic [31:0] dmem_wdata_f, dmem_wdata_n, dbg_data_f, dbg_data_n;
   logic        dmem_we_f, dmem_we_n, halted_f, halted_n, retire_f, retire_n;

   assign imem_rdata_f = imem[imem_addr_f];
   assign imem_rdata_n = imem[imem_addr_n];
   assign dmem_rdata_f = dmem_f[dmem_addr_f];
   assign dmem_rdata_n = dmem_n[dmem_addr_n];

   pipe_mips32_fwd #(.DW(32), .AW(10), .FORWARD_EN(1)) dut_f (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_f), .imem_rdata(imem_rdata_f),
      .dmem_addr(dmem_addr_f), .dmem_wdata(dmem_wdata_f), .dmem_we(dmem_we_f),
      .dmem_rdata(dmem_rdata_f), .halted(halted_f), .retire_valid(retire_f),
      .dbg_reg_addr(dbg_addr), .dbg_reg_data(dbg_data_f));

   pipe_mips32_fwd #(.DW(32), .AW(10), .FORWARD_EN(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_n), .imem_rdata(imem_rdata_n),
      .dmem_addr(dmem_addr_n), .dmem_wdata(dmem_wdata_n), .dmem_we(dmem_we_n),
      .dmem_rdata(dmem_rdata_n), .halted(halted_n), .retire_valid(retire_n),
      .dbg_reg_addr(dbg_addr), .dbg_reg_data(dbg_data_n));

   int tests_run = 0, tests_failed = 0;
   int edge_cnt, halt_e_f, halt_e_n, ret_f, ret_n, wr_f, wr_n;
   logic [9:0]  la_f, la_n;
   logic [31:0] ld_f, ld_n;

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 1024; i++) begin
         imem[i] = HLT_W; dmem_f[i] = 32'd0; dmem_n[i] = 32'd0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      edge_cnt = 0; halt_e_f = 0; halt_e_n = 0; ret_f = 0; ret_n = 0; wr_f = 0; wr_n = 0;
      la_f = '0; la_n = '0; ld_f = '0; ld_n = '0;
      rst_n = 1'b1;
   endtask

   // One clock: note the halt edge, then sample retire/store strobes mid-cycle
   task automatic step();
      @(posedge clk);
      edge_cnt++;
      #1;
      if (halted_f && halt_e_f == 0) halt_e_f = edge_cnt;
      if (halted_n && halt_e_n == 0) halt_e_n = edge_cnt;
      @(negedge clk);
      if (retire_f) ret_f++;
      if (retire_n) ret_n++;
      if (dmem_we_f) begin dmem_f[dmem_addr_f] = dmem_wdata_f; wr_f++; la_f = dmem_addr_f; ld_f = dmem_wdata_f; end
      if (dmem_we_n) begin dmem_n[dmem_addr_n] = dmem_wdata_n; wr_n++; la_n = dmem_addr_n; ld_n = dmem_wdata_n; end
   endtask

   task automatic run_prog(input int budget);
      while (!(halted_f && halted_n) && edge_cnt < budget) step();
      tests_run++;
      if (!(halted_f && halted_n)) begin
         tests_failed++;
         $display("FAIL run_timeout: halted_f=%0b halted_n=%0b after %0d edges, required both 1", halted_f, halted_n, edge_cnt);
      end
   endtask

   task automatic read_regs(input logic [4:0] r, output logic [31:0] vf, output logic [31:0] vn);
      dbg_addr = r;
      #1;
      vf = dbg_data_f;
      vn = dbg_data_n;
   endtask

   task automatic load_prog_lu();
      clear_prog();
      imem[0] = enc_i(ADDI, 5'd0, 5'd1, 16'd120);
      imem[1] = enc_i(LW,   5'd1, 5'd2, 16'd0);
      imem[2] = enc_i(ADDI, 5'd2, 5'd2, 16'd45);
      imem[3] = enc_i(SW,   5'd1, 5'd2, 16'd1);
      imem[4] = HLT_W;
      dmem_f[120] = 32'd85; dmem_n[120] = 32'd85;
   endtask

   task automatic test_reset();
      logic [31:0] vf, vn;
      clear_prog();
      rst_n = 1'b0;
      #1;
      tests_run++; if (imem_addr_f !== 10'd0 || imem_addr_n !== 10'd0) begin tests_failed++; $display("FAIL reset_pc: got %0d/%0d required 0", imem_addr_f, imem_addr_n); end
      tests_run++; if (halted_f !== 1'b0 || halted_n !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %0b/%0b required 0", halted_f, halted_n); end
      tests_run++; if (dmem_we_f !== 1'b0 || retire_f !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: we=%0b retire=%0b required 0", dmem_we_f, retire_f); end
      for (int r = 0; r < 32; r++) begin
         read_regs(5'(r), vf, vn);
         tests_run++; if (vf !== 32'd0 || vn !== 32'd0) begin tests_failed++; $display("FAIL reset_reg%0d: got %0h/%0h required 0", r, vf, vn); end
      end
   endtask

   task automatic test_load_use();
      logic [31:0] vf, vn;
      load_prog_lu();
      do_reset();
      run_prog(60);
      tests_run++; if (halt_e_f !== 10) begin tests_failed++; $display("FAIL lu_halt_edge: got %0d required 10", halt_e_f); end
      tests_run++; if (ret_f !== 5) begin tests_failed++; $display("FAIL lu_retires: got %0d required 5", ret_f); end
      tests_run++; if (wr_f !== 1 || la_f !== 10'd121 || ld_f !== 32'd130) begin tests_failed++; $display("FAIL lu_store: count %0d addr %0d data %0d required 1/121/130", wr_f, la_f, ld_f); end
      read_regs(5'd1, vf, vn);
      tests_run++; if (vf !== 32'd120) begin tests_failed++; $display("FAIL lu_r1: got %0d required 120", vf); end
      read_regs(5'd2, vf, vn);
      tests_run++; if (vf !== 32'd130) begin tests_failed++; $display("FAIL lu_r2: got %0d required 130", vf); end
      // Interlock-only core: same results, 6 stall cycles ahead of HLT
      tests_run++; if (vn !== 32'd130) begin tests_failed++; $display("FAIL nf_r2: got %0d required 130", vn); end
      tests_run++; if (halt_e_n !== 15) begin tests_failed++; $display("FAIL nf_halt_edge: got %0d required 15", halt_e_n); end
      tests_run++; if (wr_n !== 1 || la_n !== 10'd121 || ld_n !== 32'd130 || ret_n !== 5) begin tests_failed++; $display("FAIL nf_store: count %0d addr %0d data %0d retires %0d required 1/121/130/5", wr_n, la_n, ld_n, ret_n); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vf, vn;
      clear_prog();
      imem[0] = enc_i(ADDI, 5'd0, 5'd1, 16'd5);
      imem[1] = enc_r(ADD, 5'd1, 5'd1, 5'd2);
      imem[2] = enc_r(SUB, 5'd2, 5'd1, 5'd3);
      do_reset();
      run_prog(60);
      tests_run++; if (halt_e_f !== 8 || ret_f !== 4) begin tests_failed++; $display("FAIL b2b_timing: halt edge %0d retires %0d required 8/4", halt_e_f, ret_f); end
      read_regs(5'd2, vf, vn);
      tests_run++; if (vf !== 32'd10 || vn !== 32'd10) begin tests_failed++; $display("FAIL b2b_r2: got %0d/%0d required 10", vf, vn); end
      read_regs(5'd3, vf, vn);
      tests_run++; if (vf !== 32'd5 || vn !== 32'd5) begin tests_failed++; $display("FAIL b2b_r3: got %0d/%0d required 5", vf, vn); end
   endtask

   task automatic test_alu();
      logic [31:0] vf, vn;
      logic [31:0] exp_v [1:11];
      clear_prog();
      imem[0]  = enc_i(ADDI, 5'd0, 5'd1, 16'd6);
      imem[1]  = enc_i(ADDI, 5'd0, 5'd2, 16'hFFFD);
      imem[2]  = enc_r(AND_, 5'd1, 5'd2, 5'd3);
      imem[3]  = enc_r(OR_,  5'd1, 5'd2, 5'd4);
      imem[4]  = enc_r(SLT,  5'd1, 5'd2, 5'd5);
      imem[5]  = enc_r(MUL,  5'd1, 5'd1, 5'd6);
      imem[6]  = enc_i(SUBI, 5'd1, 5'd7, 16'd10);
      imem[7]  = enc_i(SLTI, 5'd1, 5'd8, 16'hFFFF);
      imem[8]  = enc_i(SLTI, 5'd2, 5'd9, 16'd5);
      imem[9]  = enc_i(ADDI, 5'd0, 5'd10, 16'd1);
      imem[10] = enc_i(ADDI, 5'd0, 5'd10, 16'd2);
      imem[11] = enc_r(ADD, 5'd10, 5'd10, 5'd11);
      exp_v[1] = 32'd6;  exp_v[2] = 32'hFFFF_FFFD; exp_v[3] = 32'd4; exp_v[4] = 32'hFFFF_FFFF;
      exp_v[5] = 32'd1;  exp_v[6] = 32'd36; exp_v[7] = 32'hFFFF_FFFC; exp_v[8] = 32'd1;
      exp_v[9] = 32'd0;  exp_v[10] = 32'd2; exp_v[11] = 32'd4;
      do_reset();
      run_prog(80);
      tests_run++; if (halt_e_f !== 17 || ret_f !== 13) begin tests_failed++; $display("FAIL alu_timing: halt edge %0d retires %0d required 17/13", halt_e_f, ret_f); end
      for (int r = 1; r <= 11; r++) begin
         read_regs(5'(r), vf, vn);
         tests_run++; if (vf !== exp_v[r] || vn !== exp_v[r]) begin tests_failed++; $display("FAIL alu_r%0d: got %0h/%0h required %0h", r, vf, vn, exp_v[r]); end
      end
   endtask

   task automatic test_branch(input logic taken_form);
      logic [31:0] vf, vn;
      clear_prog();
      imem[0] = enc_i(ADDI, 5'd0, 5'd1, 16'd0);
      imem[1] = enc_i(taken_form ? BEQZ : BNEQZ, 5'd1, 5'd0, 16'd2);
      imem[2] = enc_i(ADDI, 5'd0, 5'd5, 16'd7);
      imem[3] = enc_i(ADDI, 5'd0, 5'd6, 16'd8);
      imem[4] = enc_i(ADDI, 5'd0, 5'd7, 16'd9);
      do_reset();
      run_prog(60);
      tests_run++; if (halt_e_f !== 10 || ret_f !== (taken_form ? 4 : 6)) begin tests_failed++; $display("FAIL br%0b_timing: halt edge %0d retires %0d required 10/%0d", taken_form, halt_e_f, ret_f, taken_form ? 4 : 6); end
      read_regs(5'd5, vf, vn);
      tests_run++; if (vf !== (taken_form ? 32'd0 : 32'd7) || vn !== vf) begin tests_failed++; $display("FAIL br%0b_r5: got %0d/%0d required %0d", taken_form, vf, vn, taken_form ? 0 : 7); end
      read_regs(5'd6, vf, vn);
      tests_run++; if (vf !== (taken_form ? 32'd0 : 32'd8) || vn !== vf) begin tests_failed++; $display("FAIL br%0b_r6: got %0d/%0d required %0d", taken_form, vf, vn, taken_form ? 0 : 8); end
      read_regs(5'd7, vf, vn);
      tests_run++; if (vf !== 32'd9 || vn !== 32'd9) begin tests_failed++; $display("FAIL br%0b_r7: got %0d/%0d required 9", taken_form, vf, vn); end
   endtask

   task automatic test_r0_invalid();
      logic [31:0] vf, vn;
      clear_prog();
      imem[0] = enc_i(ADDI, 5'd0, 5'd0, 16'd55);
      imem[1] = enc_r(ADD, 5'd0, 5'd0, 5'd1);
      imem[2] = {6'b010000, 26'd0};
      imem[3] = enc_i(ADDI, 5'd0, 5'd4, 16'd9);
      imem[4] = enc_i(ADDI, 5'd0, 5'd4, 16'd9);
      do_reset();
      run_prog(60);
      tests_run++; if (halt_e_f !== 7 || ret_f !== 3 || ret_n !== 3) begin tests_failed++; $display("FAIL inv_timing: halt edge %0d retires %0d/%0d required 7/3/3", halt_e_f, ret_f, ret_n); end
      read_regs(5'd0, vf, vn);
      tests_run++; if (vf !== 32'd0 || vn !== 32'd0) begin tests_failed++; $display("FAIL r0_write: got %0d/%0d required 0", vf, vn); end
      read_regs(5'd1, vf, vn);
      tests_run++; if (vf !== 32'd0 || vn !== 32'd0) begin tests_failed++; $display("FAIL r0_read: got %0d/%0d required 0", vf, vn); end
      read_regs(5'd4, vf, vn);
      tests_run++; if (vf !== 32'd0 || vn !== 32'd0) begin tests_failed++; $display("FAIL inv_after: got %0d/%0d required 0", vf, vn); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] vf, vn;
      int bad_we;
      load_prog_lu();
      do_reset();
      repeat (6) step();
      tests_run++; if (dmem_we_f !== 1'b0 || wr_f !== 0) begin tests_failed++; $display("FAIL mid_pre_store: we %0b count %0d required 0/0", dmem_we_f, wr_f); end
      rst_n = 1'b0;
      #1;
      tests_run++; if (imem_addr_f !== 10'd0 || imem_addr_n !== 10'd0) begin tests_failed++; $display("FAIL mid_pc: got %0d/%0d required 0", imem_addr_f, imem_addr_n); end
      bad_we = 0;
      repeat (3) begin
         @(negedge clk);
         if (dmem_we_f !== 1'b0 || dmem_we_n !== 1'b0) bad_we++;
      end
      tests_run++; if (bad_we !== 0 || dmem_f[121] !== 32'd0) begin tests_failed++; $display("FAIL mid_no_store: we seen %0d times, dmem[121]=%0d required 0/0", bad_we, dmem_f[121]); end
      for (int r = 0; r < 32; r++) begin
         read_regs(5'(r), vf, vn);
         tests_run++; if (vf !== 32'd0 || vn !== 32'd0) begin tests_failed++; $display("FAIL mid_reg%0d: got %0h/%0h required 0", r, vf, vn); end
      end
      do_reset();
      run_prog(60);
      read_regs(5'd2, vf, vn);
      tests_run++; if (vf !== 32'd130 || vn !== 32'd130 || halt_e_f !== 10) begin tests_failed++; $display("FAIL mid_rerun: r2 %0d/%0d halt edge %0d required 130/130/10", vf, vn, halt_e_f); end
      tests_run++; if (wr_f !== 1 || la_f !== 10'd121 || ld_f !== 32'd130) begin tests_failed++; $display("FAIL mid_rerun_store: count %0d addr %0d data %0d required 1/121/130", wr_f, la_f, ld_f); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_back_to_back();
      test_alu();
      test_branch(1'b1);
      test_branch(1'b0);
      test_r0_invalid();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/pipe_mips32_fwd.md
Name: pipe_mips32_fwd

Overview:
- Single-clock, parametrised 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset core; successor to the team's two-phase pipeline.
- Adds full forwarding, load-use interlock, branch flush, clean halt/reset and external instruction/data memory ports.
- Sits as the CPU core between an instruction ROM/RAM and a data RAM in the risc_pro 5-stage project.

Parameters:
- DW, 32, data/register width (16..32); immediates sign-extended to DW; results truncated to DW.
- AW, 10, word-address width of PC, imem and dmem.
- FORWARD_EN, 1, 1 = EX/MEM and MEM/WB forwarding; 0 = interlock-only (stall until producer retires).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  AW  current PC.
- imem_rdata  in  32  instruction at imem_addr, combinational read.
- dmem_addr  out  AW  MEM-stage address, low AW bits of ALU result.
- dmem_wdata  out  DW  store data.
- dmem_we  out  1  store strobe for one cycle.
- dmem_rdata  in  DW  combinational read data at dmem_addr.
- halted  out  1  sticky; HLT has retired.
- retire_valid  out  1  pulses for one cycle per non-bubble instruction leaving WB.
- dbg_reg_addr  in  5  register-file debug read index.
- dbg_reg_data  out  DW  combinational Reg[dbg_reg_addr].

Behaviour:
- Encoding: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, MUL=5, LW=8, SW=9, ADDI=10, SUBI=11, SLTI=12, BNEQZ=13, BEQZ=14, HLT=63. Any other opcode is treated as HLT.
- RR results go to rd; RM results and LW go to rt.
- SLT/SLTI: unsigned compare, result 1/0. MUL keeps the low DW bits.
- Branch target = NPC + sext(imm). BEQZ is taken when A==0; BNEQZ when A!=0.
- Each pipe register carries a valid bit.
- Reset (async): PC=0, all valid=0, all 32 registers=0, halted=0, dmem_we=0, retire_valid=0.
- Register file:
  - R0 always reads 0; writes to R0 are discarded.
  - WB writes in the same cycle that ID reads the register are bypassed into ID (write-through).
- Forwarding (FORWARD_EN=1):
  - EX operands take EX/MEM ALU result over MEM/WB result over ID/EX value.
  - Forwarding applies only when the producer is valid, writes a register, and has dest != 0.
  - SW store data is forwarded the same way.
- Load-use: an LW in EX whose rt matches a consumer's rs/rt in ID causes a one-cycle stall. PC and IF/ID hold; a bubble is inserted into ID/EX.
- FORWARD_EN=0: ID stalls while any valid instruction in EX or MEM has a dest matching a source in ID. WB is covered by the write-through bypass.
- Branch:
  - Resolved in EX.
  - If taken: PC loads the target at that edge; IF/ID and ID/EX are invalidated. Penalty is 2 cycles.
  - A not-taken branch has no penalty.
- dmem_we = MEM valid and SW. Stores behind a taken branch never reach MEM valid.
- HLT:
  - When HLT decodes in ID, PC freezes and IF/ID is fed bubbles.
  - Instructions older than HLT complete.
  - When HLT retires from WB, halted is set and all state freezes until reset.
- Simultaneous events:
  - A taken branch in EX overrides a load-use stall and an HLT in ID (the HLT is flushed).
  - A stall holds HLT in ID.
- Reset mid-operation: immediate return to reset state. In-flight stores are not issued after rst_n falls.
- Timing: with edge 1 the first rising edge after rst_n deasserts, instruction n (from 1) retires at edge n+4+S, where S = stall and flush cycles inserted ahead of it.

Test Plan:
- Program ADDI R1,R0,120; LW R2,0(R1); ADDI R2,R2,45; SW R2,1(R1); HLT, with dmem[120]=85 -> dmem write addr 121 data 130, exactly one load-use stall, halted after edge 10, 5 retire pulses.
- ADDI R1,R0,5; ADD R2,R1,R1; SUB R3,R2,R1 back-to-back -> R2=10, R3=5, no stalls, HLT retire at edge n+4.
- ADDI R1,R0,0; BEQZ R1,+2; ADDI R5,R0,7; ADDI R6,R0,8; ADDI R7,R0,9; HLT -> R5=R6=0, R7=9, two squashed slots; BNEQZ variant falls through with R5=7.
- FORWARD_EN=0 rerun of scenario 1 -> identical memory and register results, strictly more cycles, never a wrong operand.
- ADDI R0,R0,55; ADD R1,R0,R0 -> R0=0, R1=0. Invalid opcode 6'b010000 -> halted, earlier instructions retired.
- Assert rst_n low while SW is in EX -> no dmem_we pulse, PC=0, all registers 0; rerunning the program gives correct results.
